// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
//   SEG_BLANK     : all segments off (active-low)
//   AN_OFF        : all anodes off (active-low)
//   seg_t         : 7-bit active-low pattern, bit6 = a ... bit0 = g
//   digit_idx_t   : digit / slot index
//   upd_payload_t : update bundle (patterns, decimal points, enables)
package seg7_pkg;

   localparam int unsigned N_DIGITS  = 4;
   localparam int unsigned SEG_W     = 7;
   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [3:0]  AN_OFF    = 4'hF;

   typedef logic [SEG_W-1:0] seg_t;
   typedef logic [1:0]       digit_idx_t;

   typedef struct packed {
      seg_t [N_DIGITS-1:0] seg;
      logic [N_DIGITS-1:0] dp;
      logic [N_DIGITS-1:0] en;
   } upd_payload_t;

   // Blank patterns, decimal points off, every digit disabled.
   localparam upd_payload_t PAYLOAD_RESET =
      upd_payload_t'({{N_DIGITS{SEG_BLANK}}, 4'hF, 4'h0});

endpackage : seg7_pkg

// File: rtl/refresh_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 while run is high and wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count enable (count holds at its value while low)
//   count      : current prescaler value
//   wrap_c     : high in the cycle whose closing edge wraps count to 0
module refresh_prescaler #(
   parameter int unsigned DIV = 100000,
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic [CW-1:0] count,
   output logic          wrap_c
);

   assign wrap_c = run && (count == CW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (run) begin
         count <= wrap_c ? '0 : count + CW'(1);
      end
   end

endmodule : refresh_prescaler

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes four staged segment patterns onto a common-anode display.
// Updates are accepted into a staging register and copied to the display
// set only at a frame boundary, so a frame never mixes old and new digits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   upd_valid/upd_ready : update handshake (accept when both high)
//   upd_seg0..3         : digit patterns, active-low (digit 0 rightmost)
//   upd_dp, upd_en      : decimal points (active-low), digit enables
//   seg, dp, an         : cathode / anode pins, active-low
//   frame_tick          : one-cycle pulse on the first cycle of each frame
module seven_seg_scanner
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_CYC   = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       upd_valid,
   output logic       upd_ready,
   input  logic [6:0] upd_seg0,
   input  logic [6:0] upd_seg1,
   input  logic [6:0] upd_seg2,
   input  logic [6:0] upd_seg3,
   input  logic [3:0] upd_dp,
   input  logic [3:0] upd_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic          started;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          wrap_c;
   digit_idx_t    slot;
   digit_idx_t    slot_nxt;
   upd_payload_t  stage;
   upd_payload_t  stage_nxt;
   upd_payload_t  disp;
   upd_payload_t  disp_nxt;
   upd_payload_t  payload_c;
   logic          pending;
   logic          pending_nxt;
   logic          accept_c;
   logic          apply_c;
   logic          in_blank_c;
   logic          lit_c;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;
   logic [3:0]    an_nxt;
   logic          tick_nxt;

   // Prescaler idles for the first edge after reset so slot 0 begins there.
   refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (started),
      .count  (count),
      .wrap_c (wrap_c)
   );

   // Outputs are registered from the post-edge counter value.
   assign count_nxt = started ? (wrap_c ? '0 : count + CW'(1)) : count;

   // Anti-ghosting window at the start of every slot.
   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign in_blank_c = 1'b0;
      end else begin : g_blank
         assign in_blank_c = (count_nxt < CW'(BLANK_CYC));
      end
   endgenerate

   // Handshake, staging and frame-boundary apply.
   always_comb begin
      payload_c        = PAYLOAD_RESET;
      payload_c.seg[0] = upd_seg0;
      payload_c.seg[1] = upd_seg1;
      payload_c.seg[2] = upd_seg2;
      payload_c.seg[3] = upd_seg3;
      payload_c.dp     = upd_dp;
      payload_c.en     = upd_en;

      accept_c    = upd_valid && upd_ready;
      // Only data staged before this edge may be applied on it.
      apply_c     = wrap_c && (slot == digit_idx_t'(N_DIGITS - 1)) && pending;
      slot_nxt    = wrap_c ? slot + digit_idx_t'(1) : slot;
      stage_nxt   = accept_c ? payload_c : stage;
      disp_nxt    = apply_c ? stage : disp;
      pending_nxt = pending;
      if (apply_c) begin
         pending_nxt = 1'b0;
      end
      if (accept_c) begin
         pending_nxt = 1'b1;
      end
   end

   // Pin drive for the slot/count being entered.
   always_comb begin
      an_nxt   = AN_OFF;
      seg_nxt  = SEG_BLANK;
      dp_nxt   = 1'b1;
      lit_c    = !in_blank_c && disp_nxt.en[slot_nxt];
      tick_nxt = (count_nxt == '0) && (slot_nxt == '0);
      if (lit_c) begin
         an_nxt  = ~(N_DIGITS'(1) << slot_nxt);
         seg_nxt = disp_nxt.seg[slot_nxt];
         dp_nxt  = disp_nxt.dp[slot_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started    <= 1'b0;
         slot       <= '0;
         stage      <= PAYLOAD_RESET;
         disp       <= PAYLOAD_RESET;
         pending    <= 1'b0;
         upd_ready  <= 1'b1;
         an         <= AN_OFF;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         started    <= 1'b1;
         slot       <= slot_nxt;
         stage      <= stage_nxt;
         disp       <= disp_nxt;
         pending    <= pending_nxt;
         upd_ready  <= !pending_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_tick <= tick_nxt;
      end
   end

endmodule : seven_seg_scanner

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (REFRESH_DIV=8; BLANK_CYC=2 and 0).
// Accepted payloads go into a scoreboard queue and are popped into the
// reference display set at the frame boundary the model predicts.
module tb_seven_seg_scanner;
   import seg7_pkg::*;

   localparam int DIV   = 8;
   localparam int BC    = 2;
   localparam int FRAME = 4 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       upd_valid = 1'b0;
   logic [6:0] upd_seg0 = 7'h7F, upd_seg1 = 7'h7F, upd_seg2 = 7'h7F, upd_seg3 = 7'h7F;
   logic [3:0] upd_dp = 4'hF, upd_en = 4'h0;
   logic       upd_ready, dp, frame_tick;
   logic [6:0] seg;
   logic [3:0] an;
   logic       ready_z, dp_z, tick_z;
   logic [6:0] seg_z;
   logic [3:0] an_z;

   int vecs = 0;
   int errs = 0;

   seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_CYC(BC)) u_dut (
      .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_seg0(upd_seg0), .upd_seg1(upd_seg1), .upd_seg2(upd_seg2), .upd_seg3(upd_seg3),
      .upd_dp(upd_dp), .upd_en(upd_en), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_CYC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(ready_z),
      .upd_seg0(upd_seg0), .upd_seg1(upd_seg1), .upd_seg2(upd_seg2), .upd_seg3(upd_seg3),
      .upd_dp(upd_dp), .upd_en(upd_en), .seg(seg_z), .dp(dp_z), .an(an_z), .frame_tick(tick_z)
   );

   always #5 clk = ~clk;

   // Reference model: k = edges since reset release.
   int           k = 0;
   upd_payload_t m_disp = PAYLOAD_RESET;
   logic         m_pend = 1'b0;
   upd_payload_t sb_q[$];

   function automatic upd_payload_t mk(input logic [6:0] s0, input logic [6:0] s1,
                                       input logic [6:0] s2, input logic [6:0] s3,
                                       input logic [3:0] d, input logic [3:0] e);
      upd_payload_t p;
      p.seg[0] = s0; p.seg[1] = s1; p.seg[2] = s2; p.seg[3] = s3;
      p.dp = d; p.en = e;
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int           nk;
      upd_payload_t nd;
      logic         np;
      logic         acc;
      if (!rst_n) begin
         k      <= 0;
         m_disp <= PAYLOAD_RESET;
         m_pend <= 1'b0;
         sb_q.delete();
      end else begin
         nk  = k + 1;
         nd  = m_disp;
         np  = m_pend;
         acc = upd_valid && !m_pend;
         if (nk > 1 && ((nk - 1) % FRAME) == 0 && np) begin
            nd = sb_q.pop_front();
            np = 1'b0;
         end
         if (acc) begin
            sb_q.push_back(mk(upd_seg0, upd_seg1, upd_seg2, upd_seg3, upd_dp, upd_en));
            np = 1'b1;
         end
         k      <= nk;
         m_disp <= nd;
         m_pend <= np;
      end
   end

   // Expected {an, seg, dp, frame_tick, upd_ready} for the current cycle.
   function automatic logic [13:0] exp_vec(input int bc);
      int         p, s, c;
      logic [3:0] a;
      logic [6:0] sg;
      logic       d, t;
      a = 4'hF; sg = 7'h7F; d = 1'b1; t = 1'b0;
      if (k > 0) begin
         p = (k - 1) % FRAME;
         s = p / DIV;
         c = p % DIV;
         t = (p == 0);
         if (c >= bc && m_disp.en[s]) begin
            a[s] = 1'b0;
            sg   = m_disp.seg[s];
            d    = m_disp.dp[s];
         end
      end
      return {a, sg, d, t, !m_pend};
   endfunction

   function automatic logic [13:0] obs();
      return {an, seg, dp, frame_tick, upd_ready};
   endfunction

   function automatic logic [13:0] obs0();
      return {an_z, seg_z, dp_z, tick_z, ready_z};
   endfunction

   task automatic drive(input upd_payload_t p);
      upd_seg0 = p.seg[0]; upd_seg1 = p.seg[1]; upd_seg2 = p.seg[2]; upd_seg3 = p.seg[3];
      upd_dp = p.dp; upd_en = p.en;
   endtask

   // Steps (without checking) until the sampled frame position equals pos.
   task automatic advance_to(input int pos);
      for (int g = 0; g < 2 * FRAME; g++) begin
         if (k > 0 && ((k - 1) % FRAME) == pos) break;
         @(posedge clk); #1;
      end
   endtask

   upd_payload_t p_scan, p_new, p_held, p_co, p_blk, p_full;

   task automatic test_reset();
      logic [13:0] e, o;
      #12;
      e = exp_vec(BC); o = obs(); vecs++;
      if (o !== e) begin errs++; $display("FAIL reset_hold got=%h exp=%h", o, e); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL reset_first k=%0d got=%h exp=%h", k, o, e); end
      end
      drive(p_scan); upd_valid = 1'b1;
      @(posedge clk); #1; upd_valid = 1'b0;
      vecs++;
      if (upd_ready !== 1'b0) begin errs++; $display("FAIL reset_accept got=%b exp=0", upd_ready); end
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      e = exp_vec(BC); o = obs(); vecs++;
      if (o !== e) begin errs++; $display("FAIL reset_async got=%h exp=%h", o, e); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < FRAME + 4; i++) begin
         @(posedge clk); #1;
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL reset_discard k=%0d got=%h exp=%h", k, o, e); end
      end
   endtask

   task automatic test_scan();
      logic [13:0] e, o;
      int          nt, last, gap_bad;
      drive(p_scan); upd_valid = 1'b1;
      @(posedge clk); #1; upd_valid = 1'b0;
      nt = 0; last = -1; gap_bad = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(posedge clk); #1;
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL scan k=%0d got=%h exp=%h", k, o, e); end
         if (frame_tick === 1'b1) begin
            if (last >= 0 && (k - last) != FRAME) gap_bad++;
            last = k; nt++;
         end
      end
      vecs++;
      if (nt != 3 || gap_bad != 0) begin
         errs++; $display("FAIL scan_tick_period ticks=%0d bad_gaps=%0d exp ticks=3 bad_gaps=0", nt, gap_bad);
      end
   endtask

   task automatic test_atomic();
      logic [13:0] e, o;
      advance_to(DIV + 2);
      drive(p_new); upd_valid = 1'b1;
      @(posedge clk); #1;
      drive(p_held);
      for (int i = 0; i < 8; i++) begin
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL atomic_hold k=%0d got=%h exp=%h", k, o, e); end
         @(posedge clk); #1;
      end
      upd_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(posedge clk); #1;
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL atomic k=%0d got=%h exp=%h", k, o, e); end
      end
      advance_to(3);
      vecs++;
      if (seg !== 7'h24 || an !== 4'b1110) begin
         errs++; $display("FAIL atomic_new_digit0 got an=%b seg=%h exp an=1110 seg=24", an, seg);
      end
   endtask

   task automatic test_coincide();
      logic [13:0] e, o;
      advance_to(FRAME - 1);
      drive(p_co); upd_valid = 1'b1;
      @(posedge clk); #1; upd_valid = 1'b0;
      vecs++;
      if (seg !== 7'h7F || upd_ready !== 1'b0 || frame_tick !== 1'b1) begin
         errs++; $display("FAIL coincide_edge got seg=%h rdy=%b tick=%b exp seg=7f rdy=0 tick=1",
                          seg, upd_ready, frame_tick);
      end
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(posedge clk); #1;
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL coincide k=%0d got=%h exp=%h", k, o, e); end
         if (i == 2) begin
            vecs++;
            if (seg !== 7'h24) begin errs++; $display("FAIL coincide_old got=%h exp=24", seg); end
         end
         if (i == FRAME + 2) begin
            vecs++;
            if (seg !== 7'h40) begin errs++; $display("FAIL coincide_new got=%h exp=40", seg); end
         end
      end
   endtask

   task automatic test_blank();
      logic [13:0] e, o;
      int          bad_an;
      drive(p_blk); upd_valid = 1'b1;
      @(posedge clk); #1; upd_valid = 1'b0;
      advance_to(0);
      advance_to(FRAME - 1);
      @(posedge clk); #1;
      bad_an = 0;
      for (int i = 0; i < FRAME; i++) begin
         e = exp_vec(BC); o = obs(); vecs++;
         if (o !== e) begin errs++; $display("FAIL blank k=%0d got=%h exp=%h", k, o, e); end
         if (an[1] !== 1'b1 || an[3] !== 1'b1) bad_an++;
         @(posedge clk); #1;
      end
      vecs++;
      if (bad_an != 0) begin errs++; $display("FAIL blank_disabled_anodes got=%0d exp=0", bad_an); end
   endtask

   task automatic test_blank0();
      logic [13:0] e, o;
      int          off_cnt;
      drive(p_full); upd_valid = 1'b1;
      @(posedge clk); #1; upd_valid = 1'b0;
      advance_to(0);
      advance_to(FRAME - 1);
      @(posedge clk); #1;
      off_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         e = exp_vec(0); o = obs0(); vecs++;
         if (o !== e) begin errs++; $display("FAIL blank0 k=%0d got=%h exp=%h", k, o, e); end
         if (an_z === 4'hF) off_cnt++;
         @(posedge clk); #1;
      end
      vecs++;
      if (off_cnt != 0) begin errs++; $display("FAIL blank0_off_cycles got=%0d exp=0", off_cnt); end
   endtask

   initial begin
      p_scan = mk(7'h01, 7'h4F, 7'h12, 7'h06, 4'hF, 4'hF);
      p_new  = mk(7'h24, 7'h30, 7'h19, 7'h20, 4'hE, 4'hF);
      p_held = mk(7'h0F, 7'h00, 7'h04, 7'h78, 4'h0, 4'hF);
      p_co   = mk(7'h40, 7'h79, 7'h24, 7'h30, 4'hB, 4'hF);
      p_blk  = mk(7'h01, 7'h4F, 7'h12, 7'h06, 4'hF, 4'b0101);
      p_full = mk(7'h02, 7'h78, 7'h00, 7'h04, 4'h7, 4'hF);
      test_reset();
      test_scan();
      test_atomic();
      test_coincide();
      test_blank();
      test_blank0();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_seven_seg_scanner
